// File: rtl/vreg_wb_collector_if.sv
// Issue / writeback / completion bundle for vreg_wb_collector.
// slave = collector side, master = issue stage and lanes.
interface vreg_wb_collector_if #(
    parameter int ADDR_WIDTH = 5
);
    logic                         issue_valid;
    logic                         issue_ready;
    logic [2:0]                   issue_vlmul;
    logic [ADDR_WIDTH-1:0]        issue_addr;
    logic                         wb_valid;
    logic [ADDR_WIDTH-1:0]        wb_addr;
    logic                         done_valid;
    logic [ADDR_WIDTH-1:0]        done_addr;
    logic [3:0]                   done_len;
    logic [(1<<ADDR_WIDTH)-1:0]   busy_map;
    logic                         err;
    logic                         err_clr;
    logic                         idle;

    modport slave (
        input  issue_valid, issue_vlmul, issue_addr,
        input  wb_valid, wb_addr, err_clr,
        output issue_ready, done_valid, done_addr, done_len,
        output busy_map, err, idle
    );

    modport master (
        output issue_valid, issue_vlmul, issue_addr,
        output wb_valid, wb_addr, err_clr,
        input  issue_ready, done_valid, done_addr, done_len,
        input  busy_map, err, idle
    );
endinterface

// File: rtl/vreg_wb_collector.sv
// Collapses per-register writeback beats into group-done events.
// Optional VREG_WB_ORDER_CHECK_EN: check beat addresses, drive sticky err.
module vreg_wb_collector #(
    parameter int ADDR_WIDTH = 5,
    parameter int DEPTH      = 4
) (
    input logic                 clk,
    input logic                 rst_n,
    vreg_wb_collector_if.slave  bus
);
    localparam int NREG = 1 << ADDR_WIDTH;
    localparam int PW   = $clog2(DEPTH);
    localparam int CW   = PW + 1;

    logic [ADDR_WIDTH-1:0] base_q [DEPTH];
    logic [3:0]            len_q  [DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [CW-1:0]         count;
    logic [2:0]            beat_cnt;
    logic [NREG-1:0]       busy_q;
    logic                  done_v_q;
    logic [ADDR_WIDTH-1:0] done_a_q;
    logic [3:0]            done_l_q;
    logic                  err_q;

    logic [3:0]            issue_len;
    logic                  issue_ready;
    logic                  accept;
    logic                  non_empty;
    logic [ADDR_WIDTH-1:0] head_base;
    logic [3:0]            head_len;
    logic [ADDR_WIDTH-1:0] exp_addr;
    logic                  beat_ok;
    logic                  last;
    logic [NREG-1:0]       set_mask;
    logic [NREG-1:0]       clr_mask;

    always_comb begin
        issue_len = 4'd1;
        unique case (1'b1)
            bus.issue_vlmul[2]: issue_len = 4'd1;
            default:            issue_len = 4'd1 << bus.issue_vlmul[1:0];
        endcase
    end

    assign issue_ready = (count < CW'(DEPTH));
    assign accept      = bus.issue_valid && issue_ready;
    assign non_empty   = (count != '0);
    assign head_base   = base_q[rd_ptr];
    assign head_len    = len_q[rd_ptr];
    assign exp_addr    = head_base + ADDR_WIDTH'(beat_cnt);

`ifdef VREG_WB_ORDER_CHECK_EN
    logic err_set;
    assign beat_ok = bus.wb_valid && non_empty && (bus.wb_addr == exp_addr);
    assign err_set = bus.wb_valid && !beat_ok;
`else
    logic unused_inputs;
    assign beat_ok       = bus.wb_valid && non_empty;
    assign unused_inputs = &{1'b0, bus.err_clr, bus.wb_addr};
`endif

    assign last = beat_ok && ({1'b0, beat_cnt} == head_len - 4'd1);

    // Wrapping offset from the issue base decides membership of register r.
    always_comb begin
        logic [ADDR_WIDTH-1:0] off;
        off      = '0;
        set_mask = '0;
        for (int r = 0; r < NREG; r++) begin
            off = ADDR_WIDTH'(r) - bus.issue_addr;
            set_mask[r] = accept && (32'(off) < 32'(issue_len));
        end
    end

    always_comb begin
        clr_mask           = '0;
        clr_mask[exp_addr] = beat_ok;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                base_q[i] <= '0;
                len_q[i]  <= '0;
            end
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            beat_cnt <= '0;
        end else begin
            if (accept) begin
                base_q[wr_ptr] <= bus.issue_addr;
                len_q[wr_ptr]  <= issue_len;
                wr_ptr         <= wr_ptr + 1'b1;
            end
            if (last) begin
                rd_ptr   <= rd_ptr + 1'b1;
                beat_cnt <= '0;
            end else if (beat_ok) begin
                beat_cnt <= beat_cnt + 3'd1;
            end
            if (accept && !last) begin
                count <= count + 1'b1;
            end else if (last && !accept) begin
                count <= count - 1'b1;
            end
        end
    end

    // Set after clear so a same-cycle issue keeps its bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= (busy_q & ~clr_mask) | set_mask;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_v_q <= 1'b0;
            done_a_q <= '0;
            done_l_q <= '0;
        end else begin
            done_v_q <= last;
            if (last) begin
                done_a_q <= head_base;
                done_l_q <= head_len;
            end
        end
    end

`ifdef VREG_WB_ORDER_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (err_set) begin
            err_q <= 1'b1;
        end else if (bus.err_clr) begin
            err_q <= 1'b0;
        end
    end
`else
    assign err_q = 1'b0;
`endif

    assign bus.issue_ready = issue_ready;
    assign bus.done_valid  = done_v_q;
    assign bus.done_addr   = done_a_q;
    assign bus.done_len    = done_l_q;
    assign bus.busy_map    = busy_q;
    assign bus.err         = err_q;
    assign bus.idle        = (count == '0) && !done_v_q;
endmodule

// File: doc/vreg_wb_collector.md
Name: vreg_wb_collector

Overview:
- Writeback-side counterpart to the register-group address sequencer.
- Accepts issued register-group descriptors (base address + vlmul) into a small in-order queue. Consumes the per-register writeback beats returned by the lanes, one address per beat.
- Collapses each group's beats back into a single group-done event.
- Maintains a per-register busy bitmap for hazard checks in the issue stage.

Parameters:
- ADDR_WIDTH, 5, vector register address width (2**ADDR_WIDTH registers).
- DEPTH, 4, outstanding group queue depth; power of two, >= 2.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- issue_valid  input  1  group descriptor offered.
- issue_ready  output  1  queue can accept a descriptor.
- issue_vlmul  input  3  LMUL encoding of the group.
- issue_addr  input  ADDR_WIDTH  group base register.
- wb_valid  input  1  writeback beat; no back-pressure.
- wb_addr  input  ADDR_WIDTH  register written by this beat.
- done_valid  output  1  one-cycle pulse: group fully written back.
- done_addr  output  ADDR_WIDTH  base register of the completed group.
- done_len  output  4  register count of the completed group (1..8).
- busy_map  output  2**ADDR_WIDTH  bit r = 1 while register r has a pending writeback.
- err  output  1  sticky protocol error.
- err_clr  input  1  clears err.
- idle  output  1  queue empty and no done pulse pending.

Behaviour:
- Reset: asynchronous, active-low, with clk as the clock. On reset:
  - Queue and beat counter cleared.
  - Outputs: issue_ready=1, done_valid=0, done_addr=0, done_len=0, busy_map=0, err=0, idle=1.
  - Reset mid-group discards all pending state; no done pulse is produced.
- Group length:
  - vlmul[2]=0: len = 1<<vlmul[1:0] (1, 2, 4, 8).
  - vlmul[2]=1 (fractional): len = 1.
- Register addresses: base+k for k=0..len-1, computed modulo 2**ADDR_WIDTH (wrap allowed, e.g. base 30, len 4 -> 30, 31, 0, 1).
- Issue handshake:
  - Accept when issue_valid && issue_ready.
  - issue_ready = (count < DEPTH), derived from registered count only. No same-cycle bypass when full, even if a group completes that cycle.
  - On accept: push {base, len}; set busy_map bits for all len registers on the next edge.
- Writeback, head entry {base, len}, beat counter beat_cnt:
  - Expected address: exp = base + beat_cnt.
  - Valid beat: wb_valid, queue non-empty, and wb_addr == exp. On a valid beat: clear busy_map[exp] and beat_cnt++.
  - Completing beat (beat_cnt == len-1 at the valid beat):
    - Pop the head and reset beat_cnt to 0.
    - Next cycle: done_valid=1, done_addr=base, done_len=len, for exactly one cycle.
  - Back-to-back groups complete on consecutive cycles, each producing its own pulse.
- Errors (set err, drop the beat; counter and busy_map unchanged):
  - wb_valid with the queue empty.
  - wb_valid with wb_addr != exp.
- err is sticky until err_clr. If err_clr and a new error occur in the same cycle, set wins.
- Simultaneous issue accept and completing beat in the same cycle: both take effect, and count is unchanged.
- Busy_map conflict: if an issue sets a bit that a wb beat clears in the same cycle, set wins.
- Latencies:
  - issue -> busy_map visible: 1 cycle.
  - wb beat -> busy bit cleared: 1 cycle.
  - Last beat -> done_valid: 1 cycle.
- idle = (count==0) && !done_valid.

Optional Feature:
- VREG_WB_ORDER_CHECK_EN
- Defined: address comparison and error reporting exactly as above.
- Undefined:
  - wb_addr is ignored; every wb_valid with a non-empty queue counts as a valid beat and clears busy_map[exp].
  - wb_valid with an empty queue is silently dropped.
  - err is tied to 0; err_clr is unused.

Test Plan:
- Reset, then issue base 8, vlmul 3'b010; send wb 8, 9, 10, 11 -> busy_map[11:8]=4'hF after issue, clears bit by bit; done_valid pulses once with done_addr=8, done_len=4; idle=1 afterwards.
- Issue base 5, vlmul 3'b101 (fractional) -> len 1; single wb 5 -> done_addr=5, done_len=1.
- Issue base 30, vlmul 3'b010 -> busy bits 30, 31, 0, 1 set; wb 30, 31, 0, 1 -> done_addr=30, done_len=4.
- Issue DEPTH=4 groups of len 1 (bases 0..3) -> issue_ready=0; 5th offer held. Send wb 0 with the 5th still offered -> 5th not accepted that cycle, accepted the next; done_addr=0.
- With VREG_WB_ORDER_CHECK_EN, issue base 4, len 2; send wb 6 -> err=1, busy bits 4 and 5 still set. Then wb 4, 5 -> done_addr=4. err_clr -> err=0.
- wb_valid with an empty queue -> err=1 (macro defined) or no effect (macro undefined). Assert rst_n=0 mid-group -> busy_map=0, no done pulse.
